jtframe_dwnld_sched: RTL and testbench



---
 rtl/jtframe_dwnld_pkg.sv | 21 ++
 rtl/jtframe_dwnld_fifo.sv | 62 ++++++
 rtl/jtframe_dwnld_sched.sv | 233 +++++++++++++++++++++++
 tb/tb_jtframe_dwnld_sched.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_dwnld_pkg.sv
// Shared types and constants for the download write scheduler.
// FIFO entries are packed as {word address, 16-bit data, 2-bit active-low mask}.
package jtframe_dwnld_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StIssue = 1'b1
    } state_e;

    localparam logic [1:0] MASK_LO = 2'b10;
    localparam logic [1:0] MASK_HI = 2'b01;
    localparam logic [1:0] MASK_W  = 2'b00;

    localparam int unsigned ENTRY_DATA_W = 16;
    localparam int unsigned ENTRY_MASK_W = 2;

    function automatic int unsigned entry_w(input int unsigned addr_w);
        return addr_w + ENTRY_DATA_W + ENTRY_MASK_W;
    endfunction

endpackage

// File: rtl/jtframe_dwnld_fifo.sv
// Small first-word fall-through FIFO. Also exposes the entry behind the head so the
// issue logic can chain writes without a bubble.
module jtframe_dwnld_fifo #(
    parameter int unsigned AW = 2,
    parameter int unsigned DW = 40
) (
    input  logic          clk_rom,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic [DW-1:0] dout_nxt,
    output logic          full,
    output logic          empty,
    output logic          multi
);

    localparam int unsigned Depth = 2**AW;

    logic [DW-1:0] mem_q [Depth];
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count;
    logic [AW-1:0] rd_nxt;
    logic          do_push, do_pop;

    assign count    = wr_ptr_q - rd_ptr_q;
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign multi    = (count > {{AW{1'b0}}, 1'b1});
    assign do_pop   = pop & ~empty;
    // A pop frees the head slot in the same cycle, so a full FIFO may still accept
    assign do_push  = push & (~full | do_pop);
    assign rd_nxt   = rd_ptr_q[AW-1:0] + 1'b1;
    assign dout     = mem_q[rd_ptr_q[AW-1:0]];
    assign dout_nxt = mem_q[rd_nxt];

    // Pointer advance
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers; reset empties the FIFO
    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage, no reset needed since the pointers define validity
    always_ff @(posedge clk_rom) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/jtframe_dwnld_sched.sv
// Download write scheduler: ioctl byte writes -> cheat RAM or queued 16-bit SDRAM writes.
// Optional byte pairing into full-word writes is enabled with JTFRAME_DWNLD_PACK_EN.
module jtframe_dwnld_sched
    import jtframe_dwnld_pkg::*;
#(
    parameter int unsigned FIFO_AW    = 2,
    parameter int unsigned SDRAM_AW   = 22,
    parameter int unsigned NVRAM_BASE = 32'h003F_0000
) (
    input  logic                clk_rom,
    input  logic                rst_n,
    input  logic                downloading,
    input  logic [24:0]         ioctl_addr,
    input  logic [7:0]          ioctl_dout,
    input  logic                ioctl_wr,
    input  logic                ioctl_ram,
    input  logic                ioctl_cheat,
    output logic [SDRAM_AW-1:0] prog_addr,
    output logic [15:0]         prog_data,
    output logic [1:0]          prog_mask,
    output logic                prog_we,
    input  logic                prog_rdy,
    output logic [7:0]          cheat_addr,
    output logic [7:0]          cheat_data,
    output logic                cheat_we,
    output logic                busy,
    output logic                overflow,
    output logic                dwnld_done
);

    localparam int unsigned EntryW = entry_w(SDRAM_AW);
    localparam logic [SDRAM_AW-1:0] NvBase = SDRAM_AW'(NVRAM_BASE);

    function automatic logic [SDRAM_AW-1:0] word_addr(input logic [24:0] a, input logic ram);
        logic [SDRAM_AW-1:0] w;
        w = a[SDRAM_AW:1];
        return ram ? w + NvBase : w;
    endfunction

    logic              nb;
    logic              push_vld, lost, pend_any, drop, pop;
    logic [EntryW-1:0] push_ent, head, head_nxt;
    logic              fifo_full, fifo_empty, fifo_multi;
    logic              unused_addr;

    assign nb          = ioctl_wr & ~ioctl_cheat;
    assign unused_addr = ^ioctl_addr;

`ifdef JTFRAME_DWNLD_PACK_EN
    logic              pend_valid_q, pend_valid_d, pend_ram_q, pend_ram_d;
    logic [24:0]       pend_addr_q, pend_addr_d;
    logic [7:0]        pend_data_q, pend_data_d;
    logic              hold_valid_q, hold_valid_d;
    logic [EntryW-1:0] hold_q, hold_d, flush_ent, new_ent;
    logic              flush_vld, new_vld, match;

    assign match = pend_valid_q && (ioctl_addr == {pend_addr_q[24:1], 1'b1})
                   && (ioctl_ram == pend_ram_q);
    assign flush_ent = {word_addr(pend_addr_q, pend_ram_q), {2{pend_data_q}}, MASK_LO};
    assign pend_any  = pend_valid_q | hold_valid_q;

    // Pair an odd byte with its pending even partner, otherwise flush the pending byte
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        pend_ram_d   = pend_ram_q;
        flush_vld    = 1'b0;
        new_vld      = 1'b0;
        new_ent      = {word_addr(ioctl_addr, ioctl_ram), ioctl_dout, pend_data_q, MASK_W};
        if (nb) begin
            if (match) begin
                new_vld      = 1'b1;
                pend_valid_d = 1'b0;
            end else begin
                flush_vld = pend_valid_q;
                if (!ioctl_addr[0]) begin
                    pend_valid_d = 1'b1;
                    pend_addr_d  = ioctl_addr;
                    pend_data_d  = ioctl_dout;
                    pend_ram_d   = ioctl_ram;
                end else begin
                    new_vld      = 1'b1;
                    pend_valid_d = 1'b0;
                    new_ent      = {word_addr(ioctl_addr, ioctl_ram), {2{ioctl_dout}}, MASK_HI};
                end
            end
        end else if (pend_valid_q && !downloading) begin
            flush_vld    = 1'b1;
            pend_valid_d = 1'b0;
        end
    end

    // One FIFO push per cycle: hold first, then flush, then the new byte; the loser waits
    always_comb begin
        push_vld     = hold_valid_q | flush_vld | new_vld;
        push_ent     = hold_valid_q ? hold_q : (flush_vld ? flush_ent : new_ent);
        hold_valid_d = hold_valid_q ? (flush_vld | new_vld) : (flush_vld & new_vld);
        hold_d       = (hold_valid_q && flush_vld) ? flush_ent : new_ent;
        lost         = hold_valid_q & flush_vld & new_vld;
    end

    // Pending byte and hold registers
    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            pend_ram_q   <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            pend_ram_q   <= pend_ram_d;
            hold_valid_q <= hold_valid_d;
            hold_q       <= hold_d;
        end
    end
`else
    assign pend_any = 1'b0;
    assign lost     = 1'b0;
    assign push_vld = nb;
    assign push_ent = {word_addr(ioctl_addr, ioctl_ram), {2{ioctl_dout}},
                       ioctl_addr[0] ? MASK_HI : MASK_LO};
`endif

    jtframe_dwnld_fifo #(
        .AW (FIFO_AW),
        .DW (EntryW)
    ) u_fifo (
        .clk_rom  (clk_rom),
        .rst_n    (rst_n),
        .push     (push_vld),
        .pop      (pop),
        .din      (push_ent),
        .dout     (head),
        .dout_nxt (head_nxt),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .multi    (fifo_multi)
    );

    state_e              state_q, state_d;
    logic [SDRAM_AW-1:0] prog_addr_q, prog_addr_d;
    logic [15:0]         prog_data_q, prog_data_d;
    logic [1:0]          prog_mask_q, prog_mask_d;
    logic                prog_we_q, prog_we_d;
    logic                ovf_q, ovf_d, dl_q, busy_q, done_q, done_d;
    logic [7:0]          cheat_addr_q, cheat_data_q;
    logic                cheat_we_q;

    assign drop   = (push_vld & fifo_full & ~pop) | lost;
    assign busy   = downloading | ~fifo_empty | prog_we_q | pend_any;
    assign ovf_d  = (ovf_q & ~(downloading & ~dl_q)) | drop;
    assign done_d = ~downloading & fifo_empty & (state_q == StIdle) & ~pend_any & busy_q;

    // Issue FSM: the head stays queued until acknowledged, then the next one is chained
    always_comb begin
        state_d     = state_q;
        prog_addr_d = prog_addr_q;
        prog_data_d = prog_data_q;
        prog_mask_d = prog_mask_q;
        prog_we_d   = prog_we_q;
        pop         = 1'b0;
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    {prog_addr_d, prog_data_d, prog_mask_d} = head;
                    prog_we_d = 1'b1;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                if (prog_rdy) begin
                    pop = 1'b1;
                    if (fifo_multi) begin
                        {prog_addr_d, prog_data_d, prog_mask_d} = head_nxt;
                    end else begin
                        prog_we_d = 1'b0;
                        state_d   = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output, status and cheat registers
    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            prog_addr_q  <= '0;
            prog_data_q  <= '0;
            prog_mask_q  <= '0;
            prog_we_q    <= 1'b0;
            ovf_q        <= 1'b0;
            dl_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cheat_addr_q <= '0;
            cheat_data_q <= '0;
            cheat_we_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            prog_addr_q  <= prog_addr_d;
            prog_data_q  <= prog_data_d;
            prog_mask_q  <= prog_mask_d;
            prog_we_q    <= prog_we_d;
            ovf_q        <= ovf_d;
            dl_q         <= downloading;
            busy_q       <= busy;
            done_q       <= done_d;
            cheat_we_q   <= ioctl_wr & ioctl_cheat;
            if (ioctl_wr && ioctl_cheat) begin
                cheat_addr_q <= ioctl_addr[7:0];
                cheat_data_q <= ioctl_dout;
            end
        end
    end

    assign prog_addr  = prog_addr_q;
    assign prog_data  = prog_data_q;
    assign prog_mask  = prog_mask_q;
    assign prog_we    = prog_we_q;
    assign overflow   = ovf_q;
    assign dwnld_done = done_q;
    assign cheat_addr = cheat_addr_q;
    assign cheat_data = cheat_data_q;
    assign cheat_we   = cheat_we_q;

endmodule

// File: tb/tb_jtframe_dwnld_sched.sv
// Scoreboard bench for jtframe_dwnld_sched. Pairing tests run when JTFRAME_DWNLD_PACK_EN is set.
`timescale 1ns/1ps
module tb_jtframe_dwnld_sched;

    typedef struct packed {
        logic [21:0] addr;
        logic [15:0] data;
        logic [1:0]  mask;
    } wr_t;

    logic        clk_rom = 1'b0;
    logic        rst_n = 1'b0;
    logic        downloading = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        ioctl_wr = 1'b0;
    logic        ioctl_ram = 1'b0;
    logic        ioctl_cheat = 1'b0;
    logic        prog_rdy = 1'b0;
    logic [21:0] prog_addr;
    logic [15:0] prog_data;
    logic [1:0]  prog_mask;
    logic        prog_we;
    logic [7:0]  cheat_addr, cheat_data;
    logic        cheat_we, busy, overflow, dwnld_done;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int cheat_cnt = 0;
    int done_cnt = 0;
    wr_t         exp_q[$];
    logic [15:0] cheat_q[$];

    always #5 clk_rom = ~clk_rom;

    jtframe_dwnld_sched #(
        .FIFO_AW    (2),
        .SDRAM_AW   (22),
        .NVRAM_BASE (32'h003F_0000)
    ) dut (
        .clk_rom     (clk_rom),
        .rst_n       (rst_n),
        .downloading (downloading),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .ioctl_wr    (ioctl_wr),
        .ioctl_ram   (ioctl_ram),
        .ioctl_cheat (ioctl_cheat),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_mask   (prog_mask),
        .prog_we     (prog_we),
        .prog_rdy    (prog_rdy),
        .cheat_addr  (cheat_addr),
        .cheat_data  (cheat_data),
        .cheat_we    (cheat_we),
        .busy        (busy),
        .overflow    (overflow),
        .dwnld_done  (dwnld_done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [21:0] a, input logic [15:0] d, input logic [1:0] m);
        exp_q.push_back(wr_t'{addr: a, data: d, mask: m});
    endtask

    // Assumes entry just after a rising edge; leaves just after the next one
    task automatic strobe(input logic [24:0] a, input logic [7:0] d, input logic ram,
                          input logic cht);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_ram = ram;
        ioctl_cheat = cht;
        ioctl_wr = 1'b1;
        @(posedge clk_rom); #1;
        ioctl_wr = 1'b0;
        ioctl_ram = 1'b0;
        ioctl_cheat = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_rom); #1;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || prog_we) && n < 60) begin
            @(posedge clk_rom); #1;
            n++;
        end
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: every acknowledged write and every cheat write is popped and compared
    initial begin
        wr_t         e;
        logic [15:0] c;
        forever begin
            @(negedge clk_rom);
            if (prog_we && prog_rdy) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr=%0h data=%0h mask=%0b, none required",
                             prog_addr, prog_data, prog_mask);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(prog_addr), 64'(e.addr));
                    check("wr_data", 64'(prog_data), 64'(e.data));
                    check("wr_mask", 64'(prog_mask), 64'(e.mask));
                end
            end
            if (cheat_we) begin
                cheat_cnt++;
                if (cheat_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cheat: got addr=%0h data=%0h, none required",
                             cheat_addr, cheat_data);
                end else begin
                    c = cheat_q.pop_front();
                    check("cheat_wr", 64'({cheat_addr, cheat_data}), 64'(c));
                end
            end
            if (dwnld_done) done_cnt++;
        end
    end

    initial begin
        int w0, c0, d0;
        // Reset state
        @(negedge clk_rom);
        check("reset_outs", 64'({prog_we, prog_addr, prog_data, prog_mask, cheat_we, cheat_addr,
                                 cheat_data, busy, overflow, dwnld_done}), 64'd0);
        @(posedge clk_rom); #1;
        rst_n = 1'b1;
        idle(2);
        check("idle_busy", 64'(busy), 64'd0);
        downloading = 1'b1;
        idle(1);
        check("dl_busy", 64'(busy), 64'd1);

        // Single odd ROM byte, two-cycle latency
        prog_rdy = 1'b1;
        expect_wr(22'h80, 16'h5A5A, 2'b01);
        ioctl_addr = 25'h101;
        ioctl_dout = 8'h5A;
        ioctl_wr = 1'b1;
        @(negedge clk_rom);
        check("lat_c0", 64'(prog_we), 64'd0);
        @(posedge clk_rom); #1;
        ioctl_wr = 1'b0;
        @(negedge clk_rom);
        check("lat_c1", 64'(prog_we), 64'd0);
        @(negedge clk_rom);
        check("lat_c2", 64'(prog_we), 64'd1);
        @(negedge clk_rom);
        check("we_one_cycle", 64'(prog_we), 64'd0);
        @(posedge clk_rom); #1;
        drain("rom_byte");

        // Cheat byte bypasses the FIFO
        w0 = wr_cnt;
        c0 = cheat_cnt;
        cheat_q.push_back(16'h1377);
        strobe(25'h13, 8'h77, 1'b0, 1'b1);
        @(negedge clk_rom);
        check("cheat_lat", 64'(cheat_we), 64'd1);
        @(posedge clk_rom); #1;
        idle(5);
        check("cheat_pulses", 64'(cheat_cnt - c0), 64'd1);
        check("cheat_no_prog", 64'(wr_cnt - w0), 64'd0);

`ifdef JTFRAME_DWNLD_PACK_EN
        // Adjacent even/odd bytes merge into one word write
        expect_wr(22'h0, 16'h2211, 2'b00);
        strobe(25'h0, 8'h11, 1'b0, 1'b0);
        idle(1);
        strobe(25'h1, 8'h22, 1'b0, 1'b0);
        drain("pair");
        // Non-adjacent even bytes are flushed alone
        expect_wr(22'h1, 16'h3333, 2'b10);
        expect_wr(22'h3, 16'h4444, 2'b10);
        strobe(25'h2, 8'h33, 1'b0, 1'b0);
        idle(1);
        strobe(25'h6, 8'h44, 1'b0, 1'b0);
        idle(3);
        check("pend_busy", 64'(busy), 64'd1);
        d0 = done_cnt;
        downloading = 1'b0;
        drain("flush");
        idle(4);
        check("pack_done_pulse", 64'(done_cnt - d0), 64'd1);
        check("pack_idle_busy", 64'(busy), 64'd0);
        downloading = 1'b1;
        idle(1);
`else
        // NVRAM byte is offset into the NVRAM region
        expect_wr(22'h3F_0002, 16'hC3C3, 2'b10);
        strobe(25'h4, 8'hC3, 1'b1, 1'b0);
        drain("nvram");

        // Overflow: head plus three more fill the FIFO, the last two are dropped
        prog_rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) check("ovf_before", 64'(overflow), 64'd0);
            if (i < 4) expect_wr(22'h8 + 22'(i / 2), {2{8'hA0 + 8'(i)}},
                                 (i % 2 == 1) ? 2'b01 : 2'b10);
            strobe(25'h10 + 25'(i), 8'hA0 + 8'(i), 1'b0, 1'b0);
            idle(1);
        end
        check("ovf_set", 64'(overflow), 64'd1);
        check("ovf_held_we", 64'(prog_we), 64'd1);
        prog_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_rom);
            check("b2b_we", 64'(prog_we), 64'd1);
        end
        @(negedge clk_rom);
        check("b2b_end", 64'(prog_we), 64'd0);
        @(posedge clk_rom); #1;
        check("ovf_all_written", 64'(exp_q.size()), 64'd0);
        check("ovf_sticky", 64'(overflow), 64'd1);
        d0 = done_cnt;
        downloading = 1'b0;
        idle(8);
        check("done_pulse", 64'(done_cnt - d0), 64'd1);
        check("done_busy", 64'(busy), 64'd0);
        downloading = 1'b1;
        idle(1);
        check("ovf_cleared", 64'(overflow), 64'd0);
`endif

        // Reset mid-transfer drops queued writes
        prog_rdy = 1'b0;
        strobe(25'h21, 8'h05, 1'b0, 1'b0);
        idle(1);
        strobe(25'h23, 8'h06, 1'b0, 1'b0);
        idle(2);
        check("rst_pre_we", 64'(prog_we), 64'd1);
        @(negedge clk_rom);
        downloading = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_outs", 64'({prog_we, prog_addr, prog_data, prog_mask, cheat_we, cheat_addr,
                               cheat_data, busy, overflow, dwnld_done}), 64'd0);
        @(posedge clk_rom); #1;
        rst_n = 1'b1;
        prog_rdy = 1'b1;
        w0 = wr_cnt;
        idle(10);
        check("rst_no_write", 64'(wr_cnt - w0), 64'd0);
        check("rst_we_low", 64'(prog_we), 64'd0);

        check("exp_empty", 64'(exp_q.size()), 64'd0);
        check("cheat_empty", 64'(cheat_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
